// File: rtl/sram_ctrl.sv
// Single-outstanding initiator for an asynchronous SRAM: sequences ce/oe/we with
// parameterised wait states and returns read data or a write acknowledge.
module sram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_WAIT    = 2,
    parameter int unsigned WR_WAIT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_wr,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [DATA_WIDTH-1:0] sram_data,
    output logic                  sram_ce,
    output logic                  sram_oe,
    output logic                  sram_we
);

    localparam int unsigned CNT_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE_RST,
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t                 state, state_d;
    logic [CNT_WIDTH-1:0]   cnt, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   drive_q, drive_d;
    logic                   capture_d;
    logic                   ready_d, resp_valid_d, resp_wr_d;
    logic                   ce_d, oe_d, we_d;

    // The bus is driven only in the three write states, from the latched word.
    assign sram_data = drive_q ? wdata_q : 'z;

    // Next state, counter and the registered view of the following cycle's pins.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        addr_d       = sram_addr;
        wdata_d      = wdata_q;
        capture_d    = 1'b0;
        resp_valid_d = 1'b0;
        resp_wr_d    = 1'b0;

        case (state)
            IDLE_RST: state_d = IDLE;
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_we) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD;
                        cnt_d   = CNT_WIDTH'(RD_WAIT);
                    end
                end
            end
            RD: begin
                if (cnt == CNT_WIDTH'(1)) begin
                    state_d      = IDLE;
                    capture_d    = 1'b1;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt - CNT_WIDTH'(1);
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = CNT_WIDTH'(WR_WAIT);
            end
            WR_PULSE: begin
                if (cnt == CNT_WIDTH'(1)) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt - CNT_WIDTH'(1);
                end
            end
            WR_HOLD: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_wr_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        ce_d    = !((state_d == RD) || (state_d == WR_SETUP) ||
                    (state_d == WR_PULSE) || (state_d == WR_HOLD));
        oe_d    = (state_d != RD);
        we_d    = (state_d != WR_PULSE);
        drive_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
    end

    // Registers; reset drops any in-flight operation without a response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE_RST;
            cnt        <= '0;
            wdata_q    <= '0;
            drive_q    <= 1'b0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_wr    <= 1'b0;
            resp_rdata <= '0;
            sram_addr  <= '0;
            sram_ce    <= 1'b1;
            sram_oe    <= 1'b1;
            sram_we    <= 1'b1;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            wdata_q    <= wdata_d;
            drive_q    <= drive_d;
            req_ready  <= ready_d;
            resp_valid <= resp_valid_d;
            resp_wr    <= resp_wr_d;
            sram_addr  <= addr_d;
            sram_ce    <= ce_d;
            sram_oe    <= oe_d;
            sram_we    <= we_d;
            if (capture_d) begin
                resp_rdata <= sram_data;
            end
        end
    end

endmodule
